out_port_uart_tx: RTL and testbench



---
 rtl/my8cpu_io_pkg.sv | 15 +
 rtl/byte_fifo.sv | 52 +++++
 rtl/out_port_uart_tx.sv | 149 ++++++++++++++
 tb/tb_out_port_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my8cpu_io_pkg.sv
// Shared types and constants for the CPU OUT-port serial stage.
package my8cpu_io_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO; push/pop take effect at the clock edge, dout shows the head combinationally.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module byte_fifo
   import my8cpu_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clock,
   input  logic                               nReset,
   input  logic                               push,
   input  logic                               pop,
   input  logic [DATA_BITS-1:0]               din,
   output logic [DATA_BITS-1:0]               dout,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
   output logic                               full,
   output logic                               empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clock) begin
      if (!nReset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/out_port_uart_tx.sv
// Queues every change of the CPU OUT byte and sends it as a UART frame (8N1, or 8E1 with OUT_UART_PARITY_EN).
// tx falls two edges after an OUT change; no backpressure, bytes arriving while full are dropped and flag overflow.
module out_port_uart_tx
   import my8cpu_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clock,
   input  logic                               nReset,
   input  logic [7:0]                         OUT_data,
   output logic                               tx,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               overflow
);

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t            state, state_next;
   logic [BW-1:0]        baud, baud_next;
   logic [2:0]           bit_cnt, bit_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [7:0]           prev;
   logic                 push, pop, tx_next, baud_last;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full, fifo_empty;
`ifdef OUT_UART_PARITY_EN
   logic                 par_bit;
`endif

   assign push      = (OUT_data != prev);
   assign busy      = (state != S_IDLE);
   assign baud_last = (baud == BAUD_LAST);

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .nReset(nReset),
      .push  (push),
      .pop   (pop),
      .din   (OUT_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (!nReset) begin
         prev     <= 8'h00;
         overflow <= 1'b0;
      end else begin
         prev <= OUT_data;
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= IDLE_LEVEL;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         tx      <= tx_next;
      end
   end

`ifdef OUT_UART_PARITY_EN
   always_ff @(posedge clock) begin
      if (!nReset)  par_bit <= 1'b0;
      else if (pop) par_bit <= ^fifo_dout;
   end
`endif

   // Pop decisions look at the registered FIFO state, so a byte pushed this edge is popped next edge.
   always_comb begin
      state_next = state;
      baud_next  = baud_last ? '0 : baud + 1'b1;
      bit_next   = bit_cnt;
      shift_next = shift;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            baud_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               state_next = S_START;
            end
         end
         S_START: begin
            if (baud_last) state_next = S_DATA;
         end
         S_DATA: begin
            if (baud_last) begin
               shift_next = shift >> 1;
               bit_next   = bit_cnt + 1'b1;
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef OUT_UART_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end
            end
         end
`ifdef OUT_UART_PARITY_EN
         S_PARITY: begin
            if (baud_last) state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_dout;
                  state_next = S_START;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            baud_next  = '0;
         end
      endcase
   end

   always_comb begin
      tx_next = IDLE_LEVEL;
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_next[0];
`ifdef OUT_UART_PARITY_EN
         S_PARITY: tx_next = par_bit;
`endif
         default:  tx_next = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: frame-level line model compared every cycle, plus directed literal checks.
// Build with OUT_UART_PARITY_EN defined to exercise the 8E1 frame.
module tb_out_port_uart_tx;

   localparam int CPB   = 10;
   localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FLEN = FBITS * CPB;

   logic       clock = 1'b0;
   logic       nReset = 1'b0;
   logic [7:0] OUT_data = 8'h00;
   logic       tx, busy, overflow;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock     (clock),
      .nReset    (nReset),
      .OUT_data  (OUT_data),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Line model: a frame is a sequence of FBITS levels, each held CPB cycles.
   logic [7:0] mq[$];
   logic [7:0] m_prev = 8'h00;
   logic [7:0] m_byte = 8'h00;
   bit         m_act = 1'b0;
   int         m_t = 0;
   bit         m_ovf = 1'b0;
   bit         m_push, m_pop;

   function automatic logic line_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef OUT_UART_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   always @(posedge clock) begin
      if (!nReset) begin
         mq.delete();
         m_prev = 8'h00;
         m_act  = 1'b0;
         m_t    = 0;
         m_ovf  = 1'b0;
      end else begin
         m_push = (OUT_data != m_prev);
         m_prev = OUT_data;
         m_pop  = (mq.size() > 0) && (!m_act || m_t == FLEN - 1);
         if (m_act) begin
            m_t++;
            if (m_t == FLEN) m_act = 1'b0;
         end
         if (m_pop) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_t    = 0;
         end
         if (m_push) begin
            if (mq.size() < DEPTH) mq.push_back(OUT_data);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("model_tx",    32'(tx),         32'(m_act ? line_bit(m_byte, m_t / CPB) : 1'b1));
         chk("model_busy",  32'(busy),       32'(m_act));
         chk("model_count", 32'(fifo_count), 32'(mq.size()));
         chk("model_ovf",   32'(overflow),   32'(m_ovf));
      end
   end

   // Independent UART receiver sampling mid-bit.
   logic [7:0] rx_q[$];
   logic       rx_pq[$];
   logic [7:0] rx_b;
   logic       rx_p;
   always begin
      @(negedge clock);
      if (nReset === 1'b1 && tx === 1'b0) begin
         repeat (CPB + CPB / 2) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            rx_b[i] = tx;
            repeat (CPB) @(negedge clock);
         end
`ifdef OUT_UART_PARITY_EN
         rx_p = tx;
         rx_pq.push_back(rx_p);
         repeat (CPB) @(negedge clock);
`endif
         chk("rx_stop", 32'(tx), 32'd1);
         rx_q.push_back(rx_b);
      end
   end

   // Window monitor: busy cycles, busy falling edges, peak FIFO occupancy.
   bit win = 1'b0;
   int busy_cyc = 0, busy_falls = 0, peak = 0;
   bit prev_busy = 1'b0;
   always @(negedge clock) begin
      if (win) begin
         busy_cyc += int'(busy);
         if (prev_busy && !busy) busy_falls++;
         prev_busy = busy;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
   end

   task automatic open_window();
      busy_cyc = 0; busy_falls = 0; peak = 0; prev_busy = 1'b0; win = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   logic [10:0] pat;
   logic [7:0]  exp4 [5];

   initial begin
      // Reset and long idle.
      nReset = 1'b0;
      OUT_data = 8'h00;
      wait_neg(3);
      chk_en = 1'b1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      nReset = 1'b1;
      wait_neg(500);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // Single frame 0xA5: latency and line levels.
`ifdef OUT_UART_PARITY_EN
      pat = 11'b10101001010;
`else
      pat = 11'b01101001010;
`endif
      OUT_data = 8'hA5;
      wait_neg(1);
      chk("lat_push_count", 32'(fifo_count), 32'd1);
      chk("lat_push_tx", 32'(tx), 32'd1);
      wait_neg(1);
      chk("lat_start_tx", 32'(tx), 32'd0);
      chk("lat_start_busy", 32'(busy), 32'd1);
      chk("lat_pop_count", 32'(fifo_count), 32'd0);
      for (int i = 0; i < FBITS; i++) begin
         chk("a5_bit", 32'(tx), 32'(pat[i]));
         wait_neg(CPB);
      end
      chk("a5_busy_end", 32'(busy), 32'd0);
      wait_neg(20);
      chk("a5_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("a5_rx", 32'(rx_q[0]), 32'hA5);
      rx_q.delete();
      rx_pq.delete();

      // Three changes spaced 10 cycles: back-to-back frames.
      open_window();
      OUT_data = 8'h01; wait_neg(10);
      OUT_data = 8'h02; wait_neg(10);
      OUT_data = 8'h03;
      wait_neg(3 * FLEN + 20);
      win = 1'b0;
      chk("b2b_busy_cycles", 32'(busy_cyc), 32'(3 * FLEN));
      chk("b2b_busy_falls", 32'(busy_falls), 32'd1);
      chk("b2b_rx_n", 32'(rx_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < rx_q.size(); i++) chk("b2b_rx", 32'(rx_q[i]), 32'(i + 1));
      rx_q.delete();
      rx_pq.delete();

      // Six changes during one frame: FIFO fills, one byte dropped.
      exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44; exp4[4] = 8'h55;
      open_window();
      OUT_data = 8'h11; wait_neg(10);
      OUT_data = 8'h22; wait_neg(10);
      OUT_data = 8'h33; wait_neg(10);
      OUT_data = 8'h44; wait_neg(10);
      OUT_data = 8'h55; wait_neg(10);
      OUT_data = 8'h66;
      wait_neg(5 * FLEN + 40);
      win = 1'b0;
      chk("ovf_peak", 32'(peak), 32'd4);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("ovf_rx_n", 32'(rx_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_rx", 32'(rx_q[i]), 32'(exp4[i]));
      rx_q.delete();
      rx_pq.delete();

      // Reset in the middle of a data bit with a byte still queued.
      OUT_data = 8'hFF; wait_neg(10);
      OUT_data = 8'h5A; wait_neg(30);
      nReset = 1'b0;
      OUT_data = 8'h00;
      wait_neg(1);
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      nReset = 1'b1;
      wait_neg(120);
      rx_q.delete();
      rx_pq.delete();
      wait_neg(150);
      chk("mid_rst_no_frame", 32'(rx_q.size()), 32'd0);
      chk("mid_rst_idle", 32'(busy), 32'd0);

      // Frame length, and parity values when enabled.
      open_window();
      OUT_data = 8'h07;
      wait_neg(FLEN + 20);
      win = 1'b0;
`ifdef OUT_UART_PARITY_EN
      chk("len_busy_cycles", 32'(busy_cyc), 32'd110);
`else
      chk("len_busy_cycles", 32'(busy_cyc), 32'd100);
`endif
      OUT_data = 8'h03;
      wait_neg(FLEN + 20);
      chk("len_rx_n", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         chk("len_rx0", 32'(rx_q[0]), 32'h07);
         chk("len_rx1", 32'(rx_q[1]), 32'h03);
      end
`ifdef OUT_UART_PARITY_EN
      chk("par_n", 32'(rx_pq.size()), 32'd2);
      if (rx_pq.size() > 1) begin
         chk("par_07", 32'(rx_pq[0]), 32'd1);
         chk("par_03", 32'(rx_pq[1]), 32'd0);
      end
`endif

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
